// File: rtl/obfuscation_controller.sv
// rtl/obfuscation_controller.sv - key loading and stream sequencer for the static-obfuscation datapath
module obfuscation_controller #(
    parameter int DATA_W       = 64,
    parameter int KEY_BYTES    = DATA_W / 8,
    parameter int IDLE_TIMEOUT = 1000,
    parameter int CNT_W        = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [7:0]        key_byte_i,
    input  logic              key_byte_valid_i,
    input  logic              key_clear_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              obf_en_o,
    output logic [DATA_W-1:0] obf_key_o,
    output logic [DATA_W-1:0] obf_data_in_o,
    input  logic [DATA_W-1:0] obf_data_out_i,
    output logic [1:0]        state_o,
    output logic [CNT_W-1:0]  word_count_o
);
    typedef enum logic [1:0] {
        ST_LOCKED  = 2'b00,
        ST_LOADING = 2'b01,
        ST_ACTIVE  = 2'b10
    } state_e;

    localparam int IDX_W  = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam int IDLE_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(KEY_BYTES - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);

    state_e              state_q;
    logic [DATA_W-1:0]   key_q;
    logic [IDX_W-1:0]    idx_q;
    logic [DATA_W-1:0]   out_data_q;
    logic                out_valid_q;
    logic [CNT_W-1:0]    word_count_q;
    logic [IDLE_W-1:0]   idle_q;

    logic active;
    logic accept;
    logic timeout_hit;
    logic relock;

    assign active      = (state_q == ST_ACTIVE);
    // A single output register: a new word may enter whenever the held one leaves this cycle.
    assign in_ready_o  = active & (~out_valid_q | out_ready_i);
    assign accept      = in_valid_i & in_ready_o;
    // A pending output word does not count as activity; only accepted inputs keep the key alive.
    assign timeout_hit = (IDLE_TIMEOUT != 0) && active && !accept && (idle_q == IDLE_LAST);
    assign relock      = key_clear_i | timeout_hit;

    // The key is gated off outside ACTIVE so a partially loaded key never reaches the datapath.
    assign obf_en_o      = active;
    assign obf_key_o     = active ? key_q : '0;
    assign obf_data_in_o = in_data_i;
    assign out_data_o    = out_data_q;
    assign out_valid_o   = out_valid_q;
    assign state_o       = state_q;
    assign word_count_o  = word_count_q;

    // Key assembly FSM, output register, word counter and idle timer; relock overrides everything.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_LOCKED;
            key_q        <= '0;
            idx_q        <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            word_count_q <= '0;
            idle_q       <= '0;
        end else if (relock) begin
            state_q      <= ST_LOCKED;
            key_q        <= '0;
            idx_q        <= '0;
            out_valid_q  <= 1'b0;
            word_count_q <= '0;
            idle_q       <= '0;
        end else begin
            case (state_q)
                ST_LOCKED, ST_LOADING: begin
                    if (key_byte_valid_i) begin
                        for (int b = 0; b < KEY_BYTES; b++) begin
                            if (idx_q == IDX_W'(b)) begin
                                key_q[DATA_W-1-8*b -: 8] <= key_byte_i;
                            end
                        end
                        if (idx_q == LAST_IDX) begin
                            state_q <= ST_ACTIVE;
                            idx_q   <= '0;
                        end else begin
                            state_q <= ST_LOADING;
                            idx_q   <= idx_q + IDX_W'(1);
                        end
                    end
                end
                ST_ACTIVE: begin
                    // Key bytes are ignored here; a reload needs an explicit clear first.
                end
                default: begin
                    state_q <= ST_LOCKED;
                end
            endcase

            if (accept) begin
                out_data_q   <= obf_data_out_i;
                out_valid_q  <= 1'b1;
                word_count_q <= word_count_q + CNT_W'(1);
            end else if (out_valid_q && out_ready_i) begin
                out_valid_q  <= 1'b0;
            end

            if (active && (IDLE_TIMEOUT != 0)) begin
                idle_q <= accept ? '0 : idle_q + IDLE_W'(1);
            end else begin
                idle_q <= '0;
            end
        end
    end
endmodule

// File: tb/tb_obfuscation_controller.sv
// tb/tb_obfuscation_controller.sv - self-checking bench for obfuscation_controller
module tb_obfuscation_controller;
    localparam logic [63:0] MAGIC = 64'h5468617473206D79;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  key_byte;
    logic        key_byte_valid;
    logic        key_clear;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        obf_en;
    logic [63:0] obf_key;
    logic [63:0] obf_data_in;
    logic [63:0] obf_data_out;
    logic [1:0]  state;
    logic [15:0] word_count;

    always #5 clk = ~clk;

    // External datapath stand-in.
    assign obf_data_out = obf_key ^ obf_data_in ^ MAGIC;

    obfuscation_controller #(
        .DATA_W(64), .KEY_BYTES(8), .IDLE_TIMEOUT(10), .CNT_W(16)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .key_byte_i(key_byte), .key_byte_valid_i(key_byte_valid), .key_clear_i(key_clear),
        .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .obf_en_o(obf_en), .obf_key_o(obf_key), .obf_data_in_o(obf_data_in),
        .obf_data_out_i(obf_data_out), .state_o(state), .word_count_o(word_count)
    );

    typedef struct {
        logic [63:0] key;
        logic [63:0] din;
        logic [63:0] dout;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] exp_q[$];
    logic [63:0] model_key = '0;
    vec_t        tbl[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Inputs are set just after a negedge; this resolves the handshakes for the next posedge.
    task automatic cycle();
        #1;
        if (key_clear) begin
            exp_q.delete();
            model_key = '0;
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_unexpected_out: got %h, expected no word", out_data);
                end else begin
                    check("sb_out_data", out_data, exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model_key ^ in_data ^ MAGIC);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_key();
        key_clear = 1'b1;
        cycle();
        key_clear = 1'b0;
    endtask

    task automatic load_key(input logic [63:0] k);
        for (int i = 0; i < 8; i++) begin
            key_byte       = k[63-8*i -: 8];
            key_byte_valid = 1'b1;
            cycle();
        end
        key_byte_valid = 1'b0;
        model_key      = k;
    endtask

    task automatic send_word(input logic [63:0] d, input logic rdy);
        in_data   = d;
        in_valid  = 1'b1;
        out_ready = rdy;
        cycle();
        in_valid  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{key: MAGIC,                 din: 64'h0123456789ABCDEF, dout: 64'h0123456789ABCDEF};
        tbl[1] = '{key: 64'h0,                 din: 64'hFFFFFFFFFFFFFFFF, dout: 64'hAB979E8B8CDF9286};
        tbl[2] = '{key: 64'hFFFFFFFFFFFFFFFF,  din: 64'h0,                dout: 64'hAB979E8B8CDF9286};
        tbl[3] = '{key: 64'h0123456789ABCDEF,  din: 64'h0123456789ABCDEF, dout: MAGIC};

        rst_n = 1'b0; key_byte = '0; key_byte_valid = 1'b0; key_clear = 1'b0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_state", 64'(state), 64'd0);
        check("rst_obf_key", obf_key, 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_word_count", 64'(word_count), 64'd0);
        check("rst_obf_en", 64'(obf_en), 64'd0);

        // Reset in the middle of loading
        for (int i = 0; i < 3; i++) begin
            key_byte = 8'hA0 + 8'(i); key_byte_valid = 1'b1; cycle();
        end
        key_byte_valid = 1'b0;
        check("loading_state", 64'(state), 64'd1);
        check("loading_no_key_leak", obf_key, 64'd0);
        rst_n = 1'b0;
        #1;
        check("midload_rst_state", 64'(state), 64'd0);
        check("midload_rst_obf_key", obf_key, 64'd0);
        check("midload_rst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Unlock with the matching key: output equals input one cycle later
        load_key(MAGIC);
        check("unlock_state", 64'(state), 64'd2);
        check("unlock_obf_en", 64'(obf_en), 64'd1);
        check("unlock_obf_key", obf_key, MAGIC);
        send_word(64'h0123456789ABCDEF, 1'b1);
        check("t2_out_valid", 64'(out_valid), 64'd1);
        check("t2_out_data", out_data, 64'h0123456789ABCDEF);
        check("t2_word_count", 64'(word_count), 64'd1);
        cycle();

        // Zero key, backpressure hold, then full-rate streaming
        clear_key();
        load_key(64'h0);
        send_word(64'h0, 1'b0);
        check("t3_out_data", out_data, MAGIC);
        for (int i = 0; i < 5; i++) begin
            in_data = 64'h1; in_valid = 1'b1; out_ready = 1'b0;
            #1;
            check("stall_in_ready", 64'(in_ready), 64'd0);
            cycle();
            check("stall_out_data", out_data, MAGIC);
            check("stall_out_valid", 64'(out_valid), 64'd1);
        end
        for (int i = 0; i < 100; i++) begin
            in_data = {$urandom(), $urandom()}; in_valid = 1'b1; out_ready = 1'b1;
            #1;
            check("stream_in_ready", 64'(in_ready), 64'd1);
            cycle();
        end
        in_valid = 1'b0;
        check("stream_word_count", 64'(word_count), 64'd101);
        cycle();
        check("stream_drained", 64'(out_valid), 64'd0);

        // Clear beats a same-cycle input and output handshake; pending word dropped
        send_word(64'hA5A5, 1'b0);
        check("t4_pending", 64'(out_valid), 64'd1);
        in_data = 64'h77; in_valid = 1'b1; out_ready = 1'b1; key_clear = 1'b1;
        cycle();
        key_clear = 1'b0; in_valid = 1'b0;
        check("clr_out_valid", 64'(out_valid), 64'd0);
        check("clr_state", 64'(state), 64'd0);
        check("clr_word_count", 64'(word_count), 64'd0);
        check("clr_obf_key", obf_key, 64'd0);
        load_key(64'h0123456789ABCDEF);
        key_byte = 8'hFF; key_byte_valid = 1'b1;
        cycle();
        key_byte_valid = 1'b0;
        check("active_kbv_key", obf_key, 64'h0123456789ABCDEF);
        check("active_kbv_state", 64'(state), 64'd2);
        send_word(64'h0123456789ABCDEF, 1'b1);
        check("t4_out_data", out_data, MAGIC);
        cycle();

        // Table of key/data vectors
        for (int v = 0; v < 4; v++) begin
            clear_key();
            load_key(tbl[v].key);
            check("tbl_state", 64'(state), 64'd2);
            send_word(tbl[v].din, 1'b0);
            check("tbl_out_valid", 64'(out_valid), 64'd1);
            check("tbl_out_data", out_data, tbl[v].dout);
            out_ready = 1'b1;
            cycle();
        end

        // Idle timeout: ten ACTIVE cycles without an accept relock
        clear_key();
        load_key(MAGIC);
        repeat (9) cycle();
        check("idle9_state", 64'(state), 64'd2);
        cycle();
        check("timeout_state", 64'(state), 64'd0);
        check("timeout_obf_key", obf_key, 64'd0);

        // An accept on the tenth cycle restarts the count
        load_key(MAGIC);
        repeat (9) cycle();
        send_word(64'h5555AAAA5555AAAA, 1'b1);
        check("restart_state", 64'(state), 64'd2);
        check("restart_word_count", 64'(word_count), 64'd1);
        repeat (9) cycle();
        check("restart_idle9_state", 64'(state), 64'd2);
        cycle();
        check("restart_timeout_state", 64'(state), 64'd0);
        check("restart_timeout_count", 64'(word_count), 64'd0);
        check("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
